// File: rtl/alu_div_responder_pkg.sv
// Shared types and constants for the multi-cycle divide/remainder responder.
package alu_div_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // operator_i[6:2] pattern shared by the four divide-class opcodes
    localparam logic [4:0] ALU_DIV_CLASS = 5'b01100;

    // operator_i[0] selects signed, operator_i[1] selects remainder
    localparam logic [6:0] ALU_DIVU = 7'b0110000;
    localparam logic [6:0] ALU_DIV  = 7'b0110001;
    localparam logic [6:0] ALU_REMU = 7'b0110010;
    localparam logic [6:0] ALU_REM  = 7'b0110011;

    function automatic logic is_div_op(input logic [6:0] op);
        return op[6:2] == ALU_DIV_CLASS;
    endfunction

endpackage

// File: rtl/alu_div_responder_if.sv
// EX-stage handshake between the issuing stage (master) and the divider (slave).
interface alu_div_responder_if #(
    parameter int WIDTH = 32
);
    logic             enable_i;
    logic [6:0]       operator_i;
    logic [WIDTH-1:0] operand_a_i;
    logic [WIDTH-1:0] operand_b_i;
    logic             ex_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             ready_o;
    logic             busy_o;

    modport master (
        output enable_i, operator_i, operand_a_i, operand_b_i, ex_ready_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  enable_i, operator_i, operand_a_i, operand_b_i, ex_ready_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/alu_div_sign_fix.sv
// Conditional two's-complement negation of two values; used to take
// magnitudes of the operands and to restore signs on quotient/remainder.
module alu_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    input  logic             negate_a,
    input  logic             negate_b,
    output logic [WIDTH-1:0] result_a,
    output logic [WIDTH-1:0] result_b
);
    // abs(MIN_INT) wraps to itself, which is the correct unsigned magnitude
    assign result_a = negate_a ? ('0 - value_a) : value_a;
    assign result_b = negate_b ? ('0 - value_b) : value_b;
endmodule

// File: rtl/alu_div_responder.sv
// Radix-2 restoring divide/remainder unit, one quotient bit per cycle,
// answering the EX-stage enable/ready handshake.
module alu_div_responder
    import alu_div_responder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input logic                core_clk,
    input logic                rst,
    alu_div_responder_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;          // dividend magnitude, shifts out MSB first, quotient shifts in
    logic [WIDTH-1:0] dvs;          // divisor magnitude
    logic [WIDTH-1:0] rem;          // partial remainder (always < dvs between steps)
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;
    logic             special;      // divide-by-zero or signed overflow
    logic [WIDTH-1:0] special_res;

    // Request decode
    logic             op_signed, op_rem, accept;
    logic             b_zero, overflow, is_special;
    logic [WIDTH-1:0] special_val, abs_a, abs_b;

    assign op_signed = bus.operator_i[0];
    assign op_rem    = bus.operator_i[1];
    assign accept    = bus.enable_i && is_div_op(bus.operator_i) &&
                       ((state == IDLE) || ((state == DONE) && bus.ex_ready_i));

    assign b_zero      = (bus.operand_b_i == '0);
    assign overflow    = op_signed && (bus.operand_a_i == MIN_INT) && (bus.operand_b_i == '1);
    assign is_special  = b_zero || overflow;
    assign special_val = b_zero ? (op_rem ? bus.operand_a_i : '1)
                                : (op_rem ? '0 : MIN_INT);

    alu_div_sign_fix #(.WIDTH(WIDTH)) u_pre_fix (
        .value_a  (bus.operand_a_i),
        .value_b  (bus.operand_b_i),
        .negate_a (op_signed && bus.operand_a_i[WIDTH-1]),
        .negate_b (op_signed && bus.operand_b_i[WIDTH-1]),
        .result_a (abs_a),
        .result_b (abs_b)
    );

    // One restoring step: extra MSB on the shifted remainder keeps the compare exact
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next, quo_next, fix_q, fix_r, final_res;

    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs});
    assign rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
    assign quo_next  = {dvd[WIDTH-2:0], rem_ge};

    alu_div_sign_fix #(.WIDTH(WIDTH)) u_post_fix (
        .value_a  (quo_next),
        .value_b  (rem_next),
        .negate_a (neg_q),
        .negate_b (neg_r),
        .result_a (fix_q),
        .result_b (fix_r)
    );

    assign final_res = special ? special_res : (is_rem ? fix_r : fix_q);

    // State register
    always_ff @(posedge core_clk or posedge rst) begin
        // NOTE: non-blocking assignments on every flop so all registers update from pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    if (bus.ex_ready_i) state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge core_clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so a mid-operation reset leaves no stale result.
        if (rst) begin
            cnt          <= '0;
            dvd          <= '0;
            dvs          <= '0;
            rem          <= '0;
            is_rem       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            special      <= 1'b0;
            special_res  <= '0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
            bus.busy_o   <= 1'b0;
        end else begin
            bus.ready_o <= (state_next == DONE);
            bus.busy_o  <= (state_next != IDLE);
            if (accept) begin
                dvd         <= abs_a;
                dvs         <= abs_b;
                rem         <= '0;
                is_rem      <= op_rem;
                neg_q       <= op_signed && (bus.operand_a_i[WIDTH-1] ^ bus.operand_b_i[WIDTH-1]);
                neg_r       <= op_signed && bus.operand_a_i[WIDTH-1];
                special     <= is_special;
                special_res <= special_val;
                // special cases need no iteration when early-out is enabled
                cnt         <= (EARLY_OUT && is_special) ? '0 : CNT_LAST;
            end else if (state == CALC) begin
                dvd <= quo_next;
                rem <= rem_next;
                if (cnt == '0) bus.result_o <= final_res;
                else           cnt          <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_div_responder.sv
// Self-checking bench: directed cases plus randomized requests against a
// plain-arithmetic reference of RISC-V divide/remainder semantics.
module tb_alu_div_responder;
    import alu_div_responder_pkg::*;

    localparam int          WIDTH   = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic core_clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   in_done = 1'b0;

    alu_div_responder_if #(.WIDTH(WIDTH)) bus ();

    alu_div_responder #(.WIDTH(WIDTH), .EARLY_OUT(1'b1)) dut (
        .core_clk (core_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    // RISC-V M-extension semantics, computed with 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_latency(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (op[0] && a == MIN_INT && b == 32'hFFFF_FFFF)) return 1;
        return WIDTH;
    endfunction

    // Issue a request (back-to-back from DONE when in_done), wait for ready_o,
    // then check latency, result and stability over `hold` stalled cycles.
    task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        int          lat;
        exp_res         = ref_result(op, a, b);
        bus.enable_i    = 1'b1;
        bus.operator_i  = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.ex_ready_i  = in_done;
        step();
        check({tag, " busy_after_accept"}, 64'(bus.busy_o), 64'd1);
        check({tag, " ready_after_accept"}, 64'(bus.ready_o), 64'd0);
        lat = 0;
        // inputs during the calculation are noise that must be ignored
        while (!bus.ready_o && lat < 64) begin
            bus.enable_i    = 1'($urandom_range(0, 1));
            bus.operator_i  = {ALU_DIV_CLASS, 2'($urandom_range(0, 3))};
            bus.operand_a_i = $urandom;
            bus.operand_b_i = $urandom;
            bus.ex_ready_i  = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        bus.enable_i   = 1'b0;
        bus.ex_ready_i = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
        check({tag, " result"}, 64'(bus.result_o), 64'(exp_res));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, " hold_result"}, 64'(bus.result_o), 64'(exp_res));
        end
        in_done = 1'b1;
    endtask

    task automatic release_done(input string tag);
        logic [31:0] held;
        held           = bus.result_o;
        bus.ex_ready_i = 1'b1;
        step();
        bus.ex_ready_i = 1'b0;
        check({tag, " release_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, " release_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, " release_result_held"}, 64'(bus.result_o), 64'(held));
        in_done = 1'b0;
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] a, b, held;

        rst             = 1'b1;
        bus.enable_i    = 1'b0;
        bus.operator_i  = '0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.ex_ready_i  = 1'b0;
        repeat (2) step();
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset result", 64'(bus.result_o), 64'd0);
        @(negedge core_clk) rst = 1'b0;
        step();

        // Directed cases
        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0);              release_done("divu_100_7");
        run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 0);              release_done("remu_100_7");
        run_op("div_m100_7", ALU_DIV, 32'hFFFF_FF9C, 32'd7, 0);         release_done("div_m100_7");
        run_op("rem_m100_7", ALU_REM, 32'hFFFF_FF9C, 32'd7, 0);         release_done("rem_m100_7");
        run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0);                    release_done("div_5_0");
        run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 0);                  release_done("remu_5_0");
        run_op("div_min_m1", ALU_DIV, MIN_INT, 32'hFFFF_FFFF, 0);       release_done("div_min_m1");
        run_op("rem_min_m1", ALU_REM, MIN_INT, 32'hFFFF_FFFF, 0);       release_done("rem_min_m1");
        run_op("divu_min_m1", ALU_DIVU, MIN_INT, 32'hFFFF_FFFF, 0);     release_done("divu_min_m1");

        // Stall in DONE, then back-to-back request with no IDLE bubble
        run_op("stall_div", ALU_DIV, 32'd1234, 32'hFFFF_FFF6, 10);
        run_op("b2b_divu_9_3", ALU_DIVU, 32'd9, 32'd3, 0);
        release_done("b2b_divu_9_3");

        // Non-divide opcode in IDLE is ignored
        held            = bus.result_o;
        bus.enable_i    = 1'b1;
        bus.operator_i  = 7'b0011000;
        bus.operand_a_i = 32'd77;
        bus.operand_b_i = 32'd3;
        step();
        bus.enable_i = 1'b0;
        check("non_div busy", 64'(bus.busy_o), 64'd0);
        check("non_div ready", 64'(bus.ready_o), 64'd0);
        check("non_div result", 64'(bus.result_o), 64'(held));

        // Reset in the middle of a calculation
        bus.enable_i    = 1'b1;
        bus.operator_i  = ALU_DIVU;
        bus.operand_a_i = 32'd1000;
        bus.operand_b_i = 32'd3;
        step();
        bus.enable_i = 1'b0;
        repeat (15) step();
        check("pre_reset busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_reset ready", 64'(bus.ready_o), 64'd0);
        check("mid_reset busy", 64'(bus.busy_o), 64'd0);
        check("mid_reset result", 64'(bus.result_o), 64'd0);
        @(negedge core_clk) rst = 1'b0;
        step();
        in_done = 1'b0;
        run_op("post_reset_divu_8_2", ALU_DIVU, 32'd8, 32'd2, 0);
        release_done("post_reset_divu_8_2");

        // Randomized requests, mixing releases and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            op = {ALU_DIV_CLASS, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 5))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = MIN_INT;  b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom_range(0, 255); b = $urandom_range(1, 17); end
                3:       begin a = $urandom; b = 32'($signed(8'($urandom))); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) release_done($sformatf("rand%0d", i));
        end
        if (in_done) release_done("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
